// File: rtl/ssd_mux.sv
// ssd_mux: time-multiplexed seven-segment display driver with ghost guard and per-digit blanking
//   clk    : clock, all state changes on rising edge
//   rst_n  : asynchronous active-low reset
//   load   : capture din into the display register
//   din    : 4*DIGITS hex nibbles, nibble 0 is the least significant digit
//   blank  : live per-digit force-off
//   seg    : registered segments, seg[0]=a .. seg[6]=g
//   an     : registered one-hot digit enable
//   frame  : one-cycle pulse after the digit index wraps to 0
// Optional: define SSD_MUX_LZS_EN to suppress leading zeros (digit 0 always shown).
module ssd_mux #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     blank,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{SEG_ACTIVE_LOW}};

    logic [PW-1:0]       presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q, disp_d;
    logic                frame_q, frame_d;
    logic [6:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [DIGITS-1:0]   lz;
    logic                adv, last, show;
    logic [3:0]          nib;
    logic [6:0]          seg_on;
    logic [DIGITS-1:0]   an_on;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

`ifdef SSD_MUX_LZS_EN
    // A digit is a leading zero when it and every more-significant nibble are zero.
    always_comb begin
        logic z;
        z  = 1'b1;
        lz = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            z     = z && (disp_q[4*i +: 4] == 4'h0);
            lz[i] = z;
        end
    end
`else
    assign lz = '0;
`endif

    always_comb begin
        adv     = presc_q == PW'(REFRESH_DIV - 1);
        last    = idx_q == IW'(DIGITS - 1);
        presc_d = adv ? '0 : presc_q + 1'b1;
        idx_d   = adv ? (last ? '0 : idx_q + 1'b1) : idx_q;
        disp_d  = load ? din : disp_q;
        frame_d = adv && last;
        nib     = disp_q[{idx_q, 2'b00} +: 4];
        // presc_q == 0 marks the first cycle of a slot: the ghost guard.
        show    = (presc_q != '0) && !blank[idx_q] && !lz[idx_q];
        seg_on  = show ? hex7(nib) : 7'h00;
        an_on   = show ? DIGITS'(1) << idx_q : '0;
        seg_d   = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
        an_d    = SEG_ACTIVE_LOW ? ~an_on : an_on;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            frame_q <= 1'b0;
            seg_q   <= SEG_OFF;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            frame_q <= frame_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg   = seg_q;
    assign an    = an_q;
    assign frame = frame_q;
endmodule

// File: tb/tb_ssd_mux.sv
// tb_ssd_mux: directed self-checking bench for ssd_mux (DIGITS=4, REFRESH_DIV=4, active-low)
module tb_ssd_mux;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] din = '0;
    logic [3:0]  blank = '0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame;

    int checks = 0;
    int errors = 0;

    // Expected display contents, pending load and the output cycle it becomes visible.
    logic [15:0] ed = '0;
    logic [15:0] ed_pend = '0;
    int          ed_at = -1;
    logic [3:0]  eb = '0;

    // Active-low glyphs 0..F.
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    ssd_mux #(.DIGITS(4), .REFRESH_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .din(din),
        .blank(blank), .seg(seg), .an(an), .frame(frame)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n counts output cycles after reset release; each slot is 4 cycles, first one is the guard.
    task automatic cycle_check(input int n);
        int         d;
        int         pos;
        logic       on;
        logic [3:0] nib;
        logic [6:0] es;
        logic [3:0] ea;
        if (n == ed_at) ed = ed_pend;
        d   = ((n - 1) / 4) % 4;
        pos = (n - 1) % 4;
        nib = ed[d*4 +: 4];
        on  = (pos != 0) && !eb[d];
`ifdef SSD_MUX_LZS_EN
        if (d > 0 && (ed >> (4 * d)) == 16'h0) on = 1'b0;
`endif
        es = on ? glyph[nib] : 7'h7F;
        ea = on ? ~(4'b0001 << d) : 4'hF;
        check($sformatf("seg n=%0d", n), 32'(seg), 32'(es));
        check($sformatf("an n=%0d", n), 32'(an), 32'(ea));
        check($sformatf("frame n=%0d", n), 32'(frame), 32'(n % 16 == 0));
    endtask

    initial begin
        #12;
        check("reset seg", 32'(seg), 32'h7F);
        check("reset an", 32'(an), 32'hF);
        check("reset frame", 32'(frame), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        load = 1'b1; din = 16'h12AF; ed_pend = 16'h12AF; ed_at = 2;
        for (int n = 1; n <= 106; n++) begin
            @(negedge clk);
            cycle_check(n);
            case (n)
                1:  load = 1'b0;
                32: begin blank = 4'b0100; eb = 4'b0100; end
                48: begin blank = 4'b0000; eb = 4'b0000; end
                55: begin load = 1'b1; din = 16'h0300; ed_pend = 16'h0300; ed_at = 57; end
                56: load = 1'b0;
                72: begin load = 1'b1; din = 16'h0040; ed_pend = 16'h0040; ed_at = 74; end
                73: load = 1'b0;
                96: begin load = 1'b1; din = 16'h1234; ed_pend = 16'h1234; ed_at = 98; end
                97: load = 1'b0;
                default: ;
            endcase
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst seg", 32'(seg), 32'h7F);
        check("async rst an", 32'(an), 32'hF);
        check("async rst frame", 32'(frame), 32'h0);
        @(negedge clk);
        check("held rst seg", 32'(seg), 32'h7F);
        check("held rst an", 32'(an), 32'hF);
        rst_n = 1'b1;
        ed = '0; ed_at = -1; eb = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            cycle_check(n);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ssd_mux.md
SSD_MUX -- requirements
Module: ssd_mux

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter REFRESH_DIV, default 50000: clock cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter SEG_ACTIVE_LOW, default 1: 1 means seg and an drive 0 for on; 0 means they drive 1 for on.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port load, input, 1: capture din when high at a rising edge.
REQ-007 SHALL have port din, input, 4*DIGITS: hex nibbles, nibble i = din[4i+3:4i]; digit 0 is least significant.
REQ-008 SHALL have port blank, input, DIGITS: per-digit force-off, sampled live, not latched.
REQ-009 SHALL have port seg, output, 7: segments, seg[0]=a through seg[6]=g, registered.
REQ-010 SHALL have port an, output, DIGITS: one-hot digit enable, registered.
REQ-011 SHALL have port frame, output, 1: one-cycle pulse when digit index wraps from DIGITS-1 to 0.

Function
REQ-012 SHALL hold a display register of 4*DIGITS bits, loaded from din on any edge with load=1; the new value is decoded from the next edge onward.
REQ-013 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; terminal count is the advance strobe.
REQ-014 SHALL hold a digit index idx, 0..DIGITS-1; on each advance strobe: idx = idx+1, or 0 if idx = DIGITS-1 (wrap).
REQ-015 SHALL assert frame for exactly the cycle after an advance that wraps idx to 0; frame SHALL pulse every advance when DIGITS=1.
REQ-016 SHALL decode the selected nibble to standard hex glyphs: 0-9, A, b, C, d, E, F, with segments a..g per common 7-segment convention.
REQ-017 SHALL drive seg and an from registers; output latency is 1 cycle from idx/display-register change.
REQ-018 SHALL insert a ghost guard: in the first output cycle of each digit slot, all an and all seg SHALL be off; the digit is shown for the remaining REFRESH_DIV-1 cycles.
REQ-019 SHALL turn off all seg and keep the an bit off for the whole slot when blank[idx]=1.
REQ-020 SHALL, when load coincides with an advance strobe, display the newly loaded nibble in the new slot.
REQ-021 SHALL apply the SEG_ACTIVE_LOW polarity uniformly to seg and an; "off" means the inactive level.
REQ-022 SHALL leave load with no effect on prescaler, idx or frame.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force: prescaler=0, idx=0, display register=0, frame=0, all seg off, all an off.
REQ-024 SHALL, on reset release, start a fresh slot for digit 0 including its ghost guard cycle.
REQ-025 SHALL abort any slot in progress on reset assertion mid-operation, with no partial load retained.

Configuration
REQ-026 SHALL support macro SSD_MUX_LZS_EN enabling leading-zero suppression.
REQ-027 SHALL, with SSD_MUX_LZS_EN defined, blank digit i>0 (seg off, an off) when nibble i and all more-significant nibbles are 0; digit 0 is never suppressed.
REQ-028 SHALL, without SSD_MUX_LZS_EN, display every nibble, including zeros, with no added logic.

Verification (DIGITS=4, REFRESH_DIV=4, SEG_ACTIVE_LOW=1)
REQ-029 SHALL cover reset then load din=16'h12AF: guard cycle, then an=4'b1110 with seg showing F for 3 cycles; then 4'b1101 with A, 4'b1011 with 2, 4'b0111 with 1, in repeating order.
REQ-030 SHALL cover the frame pulse: exactly one frame pulse every 16 cycles, in the cycle after idx wraps 3->0.
REQ-031 SHALL cover blanking: blank=4'b0100 -> during slot 2, an=4'b1111 and seg=7'h7F for all 4 cycles; other slots unaffected.
REQ-032 SHALL cover load coincident with the 1->2 advance, din=16'h0300: slot 2 shows 3 immediately.
REQ-033 SHALL cover SSD_MUX_LZS_EN with din=16'h0040: slots 3 and 0 vs 1 and 2 handled correctly; digits 3 and 2 blank, digit 1 shows 4, digit 0 shows 0; without the macro, digits 3 and 2 show 0.
REQ-034 SHALL cover rst_n pulled low mid-slot 2: outputs go off asynchronously; after release, first display is digit 0 showing 0 after one guard cycle.
